// File: rtl/boson_stream_pkg.sv
// Shared types and defaults for the Boson camera stream path.
package boson_stream_pkg;

    // Capture FSM states, also exported on the debug state port.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    // Filler for the upper half of the last word of an odd-length frame.
    localparam logic [15:0] PAD_VALUE_DEFAULT = 16'h0000;

endpackage

// File: rtl/boson_pixel_packer_if.sv
// Packed-word stream between the pixel packer and the DMA stage.
// Handshake: a word transfers on a rising clk edge where valid & ready are both high;
// once valid is raised, data and valid hold steady until that transfer happens.
interface boson_pixel_packer_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/boson_pixel_obuf.sv
// Output buffer: synchronous FIFO with a valid/ready read side.
// A push into a full FIFO with no simultaneous pop is dropped and flagged.
module boson_pixel_obuf #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          drop,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam int AW = $clog2(DEPTH);

    // The extra top pointer bit tells full apart from empty.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          empty;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/boson_pixel_packer.sv
// Boson pixel packer: captures whole frames of 16-bit pixels, packs pairs into
// words {pixel n+1, pixel n} and feeds them through an output FIFO to the DMA stage.
// Optional build macro PIXEL_PACKER_DROP_CNT_EN adds drop_cnt_o, a saturating
// count of dropped words cleared when cfg_enable_i rises.
module boson_pixel_packer
    import boson_stream_pkg::*;
#(
    parameter int                WB_DW      = 32,
    parameter int                PIX_DW     = 16,
    parameter int                OBUF_DEPTH = 4,
    parameter int                CNT_W      = 24,
    parameter logic [PIX_DW-1:0] PAD_VALUE  = PIX_DW'(PAD_VALUE_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_enable_i,
    input  logic                 cfg_continuous_i,
    input  logic [CNT_W-1:0]     cfg_frame_pix_i,
    input  logic [PIX_DW-1:0]    pix_data_i,
    input  logic                 pix_valid_i,
    input  logic                 pix_sof_i,
    boson_pixel_packer_if.master stream_m,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 overflow_o,
`ifdef PIXEL_PACKER_DROP_CNT_EN
    output logic [15:0]          drop_cnt_o,
`endif
    output state_t               state_o
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   pix_cnt_q;
    logic [CNT_W-1:0]   last_idx_q;
    logic [CNT_W-1:0]   cfg_last;
    logic [CNT_W-1:0]   idx_cur;
    logic [CNT_W-1:0]   last_cur;
    logic [PIX_DW-1:0]  hold_q;
    logic               pad_pend_q;
    logic               enable_q;
    logic               enable_rise;
    logic               overflow_q;
    logic               take_pix;
    logic               short_frame;
    logic               is_last;
    logic               push;
    logic [WB_DW-1:0]   push_data;
    logic               drop;

    // A frame size of 0 behaves like a single-pixel frame.
    assign cfg_last    = (cfg_frame_pix_i == '0) ? '0 : cfg_frame_pix_i - 1'b1;
    assign enable_rise = cfg_enable_i && !enable_q;
    assign is_last     = take_pix && (idx_cur == last_cur);

    // Next-state logic and per-pixel index selection.
    always_comb begin
        state_d     = state_q;
        take_pix    = 1'b0;
        short_frame = 1'b0;
        idx_cur     = pix_cnt_q;
        last_cur    = last_idx_q;
        case (state_q)
            IDLE: begin
                if (cfg_enable_i) state_d = ARMED;
            end
            ARMED: begin
                if (pix_valid_i && pix_sof_i) begin
                    take_pix = 1'b1;
                    idx_cur  = '0;
                    last_cur = cfg_last;
                    state_d  = CAPTURE;
                end else if (!cfg_enable_i) begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                if (pix_valid_i) begin
                    take_pix = 1'b1;
                    // An early SOF abandons the partial frame and restarts at index 0.
                    if (pix_sof_i) begin
                        idx_cur     = '0;
                        short_frame = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = (cfg_enable_i && cfg_continuous_i) ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (take_pix && (idx_cur == last_cur)) state_d = FLUSH;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Pixel counter, frame length latch and low-half holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q  <= '0;
            last_idx_q <= '0;
            hold_q     <= '0;
            pad_pend_q <= 1'b0;
        end else if (take_pix) begin
            pix_cnt_q  <= idx_cur + 1'b1;
            last_idx_q <= last_cur;
            pad_pend_q <= is_last && !idx_cur[0];
            if (!idx_cur[0]) hold_q <= pix_data_i;
        end else if (state_q == FLUSH) begin
            pix_cnt_q  <= '0;
            pad_pend_q <= 1'b0;
        end
    end

    // Odd pixels complete a word right away; an odd-length frame pads in FLUSH.
    always_comb begin
        push      = 1'b0;
        push_data = {pix_data_i, hold_q};
        if (take_pix && idx_cur[0]) begin
            push = 1'b1;
        end else if (state_q == FLUSH && pad_pend_q) begin
            push      = 1'b1;
            push_data = {PAD_VALUE, hold_q};
        end
    end

    // Sticky overflow: cleared on enable rising, set by drops or short frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            enable_q <= cfg_enable_i;
            if (enable_rise)          overflow_q <= 1'b0;
            if (drop || short_frame)  overflow_q <= 1'b1;
        end
    end

`ifdef PIXEL_PACKER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating dropped-word counter, cleared on enable rising.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (enable_rise) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    boson_pixel_obuf #(
        .DW    (WB_DW),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .drop      (drop),
        .out_data  (stream_m.data),
        .out_valid (stream_m.valid),
        .out_ready (stream_m.ready)
    );

    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = (state_q == FLUSH);
    assign overflow_o   = overflow_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_boson_pixel_packer.sv
// Self-checking bench for boson_pixel_packer: frame table plus corner-case sequences.
module tb_boson_pixel_packer;
    import boson_stream_pkg::*;

    localparam int CNT_W = 24;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             cfg_enable;
    logic             cfg_continuous;
    logic [CNT_W-1:0] cfg_frame_pix;
    logic [15:0]      pix_data;
    logic             pix_valid;
    logic             pix_sof;
    logic             busy;
    logic             frame_done;
    logic             overflow;
    state_t           state;
`ifdef PIXEL_PACKER_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    boson_pixel_packer_if #(.DW(32)) stream_if ();

    boson_pixel_packer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_enable_i     (cfg_enable),
        .cfg_continuous_i (cfg_continuous),
        .cfg_frame_pix_i  (cfg_frame_pix),
        .pix_data_i       (pix_data),
        .pix_valid_i      (pix_valid),
        .pix_sof_i        (pix_sof),
        .stream_m         (stream_if),
        .busy_o           (busy),
        .frame_done_o     (frame_done),
        .overflow_o       (overflow),
`ifdef PIXEL_PACKER_DROP_CNT_EN
        .drop_cnt_o       (drop_cnt),
`endif
        .state_o          (state)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic [31:0] last_word;
    int          words_seen = 0;
    int          done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Words transfer on the next rising edge when valid & ready are seen here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stream_if.valid && stream_if.ready) begin
                words_seen++;
                last_word = stream_if.data;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got %h expected none", stream_if.data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("word", stream_if.data, mon_exp);
                end
            end
            if (frame_done) done_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends n pixels base, base+1, ... with SOF on the first; optionally models the words.
    task automatic send_frame(input logic [15:0] base, input int n, input bit model, input bit pad);
        logic [15:0] prev;
        logic [15:0] cur;
        prev = '0;
        for (int i = 0; i < n; i++) begin
            cur       = base + 16'(i);
            pix_data  = cur;
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            if (model && (i % 2 == 1)) exp_q.push_back({cur, prev});
            if (model && pad && (i == n - 1) && (i % 2 == 0)) exp_q.push_back({16'h0000, cur});
            prev = cur;
            tick(1);
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain got %0d words pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(3);
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        int          fp;
        logic [15:0] base;
        int          exp_words;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{fp: 8, base: 16'h0001, exp_words: 4, exp_last: 32'h0008_0007};
        vecs[1] = '{fp: 5, base: 16'h0001, exp_words: 3, exp_last: 32'h0000_0005};
        vecs[2] = '{fp: 1, base: 16'h00A0, exp_words: 1, exp_last: 32'h0000_00A0};
        vecs[3] = '{fp: 0, base: 16'h0B00, exp_words: 1, exp_last: 32'h0000_0B00};
        vecs[4] = '{fp: 2, base: 16'hFFFE, exp_words: 1, exp_last: 32'hFFFF_FFFE};
        vecs[5] = '{fp: 7, base: 16'h1230, exp_words: 4, exp_last: 32'h0000_1236};

        cfg_enable      = 1'b0;
        cfg_continuous  = 1'b0;
        cfg_frame_pix   = '0;
        pix_data        = '0;
        pix_valid       = 1'b0;
        pix_sof         = 1'b0;
        stream_if.ready = 1'b1;
        rst_n           = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset state.
        check("rst_valid", 32'(stream_if.valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
`ifdef PIXEL_PACKER_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        // Single frames, one-shot mode.
        foreach (vecs[r]) begin
            cfg_frame_pix  = CNT_W'(vecs[r].fp);
            cfg_continuous = 1'b0;
            cfg_enable     = 1'b1;
            words_seen     = 0;
            done_seen      = 0;
            tick(2);
            check("row_armed", 32'(state), 32'(ARMED));
            send_frame(vecs[r].base, (vecs[r].fp == 0) ? 1 : vecs[r].fp, 1'b1, 1'b1);
            cfg_enable = 1'b0;
            wait_drain("row");
            check("row_words", 32'(words_seen), 32'(vecs[r].exp_words));
            check("row_last", last_word, vecs[r].exp_last);
            check("row_done", 32'(done_seen), 32'd1);
            check("row_busy", 32'(busy), 32'd0);
            check("row_overflow", 32'(overflow), 32'd0);
        end

        // Pixels before SOF while ARMED are ignored.
        cfg_frame_pix = 24'd4;
        cfg_enable    = 1'b1;
        words_seen    = 0;
        done_seen     = 0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            pix_data  = 16'hDEA0 + 16'(i);
            pix_valid = 1'b1;
            pix_sof   = 1'b0;
            tick(1);
        end
        pix_valid = 1'b0;
        tick(2);
        check("presof_valid", 32'(stream_if.valid), 32'd0);
        check("presof_state", 32'(state), 32'(ARMED));
        send_frame(16'h0040, 4, 1'b1, 1'b1);
        cfg_enable = 1'b0;
        wait_drain("presof");
        check("presof_words", 32'(words_seen), 32'd2);
        check("presof_done", 32'(done_seen), 32'd1);

        // Short frame: SOF after 3 pixels of an 8-pixel frame.
        cfg_frame_pix = 24'd8;
        cfg_enable    = 1'b1;
        words_seen    = 0;
        done_seen     = 0;
        tick(2);
        send_frame(16'h0010, 3, 1'b1, 1'b0);
        send_frame(16'h0020, 8, 1'b1, 1'b1);
        cfg_enable = 1'b0;
        wait_drain("short");
        check("short_overflow", 32'(overflow), 32'd1);
        check("short_words", 32'(words_seen), 32'd5);
        check("short_done", 32'(done_seen), 32'd1);

        // Overflow: consumer stalled for a 16-pixel frame.
        stream_if.ready = 1'b0;
        cfg_frame_pix   = 24'd16;
        cfg_enable      = 1'b1;
        words_seen      = 0;
        done_seen       = 0;
        tick(2);
        check("ovf_cleared_on_enable", 32'(overflow), 32'd0);
        send_frame(16'h0001, 16, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) exp_q.push_back({16'(2 * k + 2), 16'(2 * k + 1)});
        cfg_enable = 1'b0;
        tick(3);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_valid_held", 32'(stream_if.valid), 32'd1);
        check("ovf_data_held", stream_if.data, 32'h0002_0001);
        check("ovf_done", 32'(done_seen), 32'd1);
        check("ovf_state", 32'(state), 32'(IDLE));
`ifdef PIXEL_PACKER_DROP_CNT_EN
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
`endif
        stream_if.ready = 1'b1;
        wait_drain("ovf");
        check("ovf_words", 32'(words_seen), 32'd4);
        check("ovf_sticky", 32'(overflow), 32'd1);
        cfg_enable = 1'b1;
        tick(2);
        check("ovf_clear", 32'(overflow), 32'd0);
`ifdef PIXEL_PACKER_DROP_CNT_EN
        check("ovf_drop_cnt_clear", 32'(drop_cnt), 32'd0);
`endif
        cfg_enable = 1'b0;
        tick(2);

        // Continuous mode: two frames back to back.
        cfg_frame_pix  = 24'd4;
        cfg_continuous = 1'b1;
        cfg_enable     = 1'b1;
        words_seen     = 0;
        done_seen      = 0;
        tick(2);
        send_frame(16'h0100, 4, 1'b1, 1'b1);
        tick(2);
        check("cont_rearmed", 32'(state), 32'(ARMED));
        check("cont_busy", 32'(busy), 32'd1);
        send_frame(16'h0200, 4, 1'b1, 1'b1);
        tick(2);
        check("cont_done", 32'(done_seen), 32'd2);
        check("cont_state", 32'(state), 32'(ARMED));
        cfg_enable = 1'b0;
        tick(2);
        check("cont_idle", 32'(state), 32'(IDLE));
        wait_drain("cont");
        check("cont_words", 32'(words_seen), 32'd4);
        cfg_continuous = 1'b0;

        // Reset mid-frame with two words buffered.
        stream_if.ready = 1'b0;
        cfg_frame_pix   = 24'd16;
        cfg_enable      = 1'b1;
        tick(2);
        send_frame(16'h0300, 5, 1'b0, 1'b0);
        tick(1);
        check("rstmid_valid_before", 32'(stream_if.valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid_now", 32'(stream_if.valid), 32'd0);
        check("rstmid_busy_now", 32'(busy), 32'd0);
        cfg_enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("rstmid_state", 32'(state), 32'(IDLE));
        check("rstmid_valid_after", 32'(stream_if.valid), 32'd0);
        words_seen      = 0;
        stream_if.ready = 1'b1;
        tick(5);
        check("rstmid_no_words", 32'(words_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
